// File: rtl/slv_bar_fabric_pkg.sv
// Shared types and helpers for the slave-bus BAR fabric: BAR-hit decode and
// BAR0 register-map offsets expressed in terms of the control register count.
package slv_bar_fabric_pkg;

    localparam int MAX_BARS = 7;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } bar_sel_t;

    // Fixed words sit directly after the RW control registers.
    function automatic int ofs_id(input int num_regs);
        return num_regs;
    endfunction
    function automatic int ofs_cntl(input int num_regs);
        return num_regs + 1;
    endfunction
    function automatic int ofs_cnth(input int num_regs);
        return num_regs + 2;
    endfunction
    function automatic int ofs_stat(input int num_regs);
        return num_regs + 3;
    endfunction

    function automatic bar_sel_t bar_decode(input logic [MAX_BARS-1:0] hits);
        bar_sel_t s;
        s = '0;
        for (int b = MAX_BARS - 1; b >= 0; b--) begin
            if (hits[b]) begin
                s.hit = 1'b1;
                s.idx = 3'(b);
            end
        end
        return s;
    endfunction

    function automatic logic bar_multi(input logic [MAX_BARS-1:0] hits);
        return (hits & (hits - 7'd1)) != '0;
    endfunction

endpackage

// File: rtl/slv_rd_pipe.sv
// Read-return delay line: DEPTH stages of {valid, data}; data stages only load
// on valid so each stage holds the last returned word.
module slv_rd_pipe #(
    parameter int DEPTH = 0
) (
    input  logic        clk_125,
    input  logic        rstn,
    input  logic        in_vld,
    input  logic [15:0] in_dat,
    output logic        out_vld,
    output logic [15:0] out_dat
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign out_vld = in_vld;
            assign out_dat = in_dat;
        end else begin : g_pipe
            logic [DEPTH-1:0]       vld_pipe;
            logic [DEPTH-1:0][15:0] dat_pipe;

            always_ff @(posedge clk_125 or negedge rstn) begin
                if (!rstn) begin
                    vld_pipe <= '0;
                    dat_pipe <= '0;
                end else begin
                    vld_pipe[0] <= in_vld;
                    if (in_vld) dat_pipe[0] <= in_dat;
                    for (int s = 1; s < DEPTH; s++) begin
                        vld_pipe[s] <= vld_pipe[s-1];
                        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
                    end
                end
            end

            assign out_vld = vld_pipe[DEPTH-1];
            assign out_dat = dat_pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/slv_bar_fabric.sv
// Slave-bus fabric between the TLP slave port and BAR targets: hit decode,
// BAR0 register bank, per-BAR memory enables and latency-aligned read return.
module slv_bar_fabric
    import slv_bar_fabric_pkg::*;
#(
    parameter int          NUM_BARS = 3,
    parameter int          NUM_REGS = 8,
    parameter int          REG_AW   = 4,
    parameter int          READ_LAT = 1,
    parameter logic [15:0] ID_VALUE = 16'h8010
) (
    input  logic                         clk_125,
    input  logic                         rstn,
    input  logic [6:0]                   slv_bar_i,
    input  logic                         slv_ce_i,
    input  logic                         slv_we_i,
    input  logic [19:1]                  slv_adr_i,
    input  logic [15:0]                  slv_dat_i,
    input  logic [1:0]                   slv_sel_i,
    output logic [15:0]                  slv_dat_o,
    output logic                         slv_rvld_o,
    output logic [NUM_BARS-1:0]          mem_ce_o,
    input  logic [NUM_BARS-1:0][15:0]    mem_dat_i,
    output logic [NUM_REGS-1:0][15:0]    ctrl_o,
    input  logic [15:0]                  stat_i,
    output logic [7:0]                   err_cnt_o
);

    localparam int OFS_ID   = ofs_id(NUM_REGS);
    localparam int OFS_CNTL = ofs_cntl(NUM_REGS);
    localparam int OFS_CNTH = ofs_cnth(NUM_REGS);
    localparam int OFS_STAT = ofs_stat(NUM_REGS);

    logic [MAX_BARS-1:0]         hits;
    bar_sel_t                    hit_sel, rd_sel_q;
    logic                        wr0, rd0, dec_err, rd_vld_q, pipe_vld;
    logic [REG_AW-1:0]           ofs;
    logic [NUM_REGS-1:0][15:0]   ctrl_q;
    logic [31:0]                 cnt_q;
    logic [15:0]                 shadow_q, sticky_q, w1c, rd_word, rdata_q;
    logic [15:0]                 mux_dat, pipe_dat, dat_hold;
    logic                        unused_bits;

    // Only the low NUM_BARS hit lines take part in decode.
    always_comb begin
        hits = '0;
        hits[NUM_BARS-1:0] = slv_bar_i[NUM_BARS-1:0];
    end

    assign hit_sel = bar_decode(hits);
    assign dec_err = slv_ce_i & (~hit_sel.hit | bar_multi(hits));
    assign wr0     = slv_ce_i & slv_we_i & hit_sel.hit & (hit_sel.idx == 3'd0);
    assign rd0     = slv_ce_i & ~slv_we_i & hit_sel.hit & (hit_sel.idx == 3'd0);
    assign ofs     = slv_adr_i[REG_AW:1];
    assign w1c     = (wr0 && int'(ofs) == OFS_STAT) ?
                     ({{8{slv_sel_i[1]}}, {8{slv_sel_i[0]}}} & slv_dat_i) : 16'h0;

    always_comb begin
        mem_ce_o = '0;
        for (int b = 1; b < NUM_BARS; b++)
            mem_ce_o[b] = slv_ce_i & hit_sel.hit & (hit_sel.idx == 3'(b));
    end

    always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn) begin
            ctrl_q    <= '0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            sticky_q  <= '0;
            err_cnt_o <= '0;
        end else begin
            cnt_q <= cnt_q + 32'd1;
            // Reading the low half freezes the high half for a tear-free 32-bit read.
            if (rd0 && int'(ofs) == OFS_CNTL) shadow_q <= cnt_q[31:16];
            sticky_q <= (sticky_q & ~w1c) | stat_i;
            if (dec_err && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr0 && int'(ofs) == k) begin
                    if (slv_sel_i[0]) ctrl_q[k][7:0]  <= slv_dat_i[7:0];
                    if (slv_sel_i[1]) ctrl_q[k][15:8] <= slv_dat_i[15:8];
                end
            end
        end
    end

    assign ctrl_o = ctrl_q;

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++)
            if (int'(ofs) == k) rd_word = ctrl_q[k];
        if (int'(ofs) == OFS_ID)   rd_word = ID_VALUE;
        if (int'(ofs) == OFS_CNTL) rd_word = cnt_q[15:0];
        if (int'(ofs) == OFS_CNTH) rd_word = shadow_q;
        if (int'(ofs) == OFS_STAT) rd_word = sticky_q;
    end

    // BAR0 data is registered so it lines up with the one-cycle memory Q buses.
    always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn) begin
            rdata_q  <= '0;
            rd_vld_q <= 1'b0;
            rd_sel_q <= '0;
        end else begin
            if (rd0) rdata_q <= rd_word;
            rd_vld_q <= slv_ce_i & ~slv_we_i;
            rd_sel_q <= hit_sel;
        end
    end

    always_comb begin
        mux_dat = '0;
        if (rd_sel_q.hit) begin
            if (rd_sel_q.idx == 3'd0) mux_dat = rdata_q;
            for (int b = 1; b < NUM_BARS; b++)
                if (rd_sel_q.idx == 3'(b)) mux_dat = mem_dat_i[b];
        end
    end

    slv_rd_pipe #(.DEPTH(READ_LAT - 1)) u_rd_pipe (
        .clk_125 (clk_125),
        .rstn    (rstn),
        .in_vld  (rd_vld_q),
        .in_dat  (mux_dat),
        .out_vld (pipe_vld),
        .out_dat (pipe_dat)
    );

    always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn)         dat_hold <= '0;
        else if (pipe_vld) dat_hold <= pipe_dat;
    end

    assign slv_dat_o   = pipe_vld ? pipe_dat : dat_hold;
    assign slv_rvld_o  = pipe_vld;
    assign unused_bits = ^{slv_adr_i, slv_bar_i, mem_dat_i[0]};

endmodule

// File: tb/tb_slv_bar_fabric.sv
// Bench for slv_bar_fabric: directed vector table, hand sequences for counter,
// sticky and reset corners, and random traffic against a reference model.
module tb_slv_bar_fabric;

    localparam int          NB  = 3;
    localparam int          NR  = 8;
    localparam int          AW  = 4;
    localparam int          RL  = 3;
    localparam logic [15:0] IDV = 16'h8010;

    logic                 clk_125 = 1'b0;
    logic                 rstn = 1'b0;
    logic [6:0]           slv_bar_i = '0;
    logic                 slv_ce_i = 1'b0, slv_we_i = 1'b0;
    logic [19:1]          slv_adr_i = '0;
    logic [15:0]          slv_dat_i = '0;
    logic [1:0]           slv_sel_i = '0;
    logic [15:0]          slv_dat_o;
    logic                 slv_rvld_o;
    logic [NB-1:0]        mem_ce_o;
    logic [NB-1:0][15:0]  mem_dat_i = '0;
    logic [NR-1:0][15:0]  ctrl_o;
    logic [15:0]          stat_i = '0;
    logic [7:0]           err_cnt_o;

    slv_bar_fabric #(.NUM_BARS(NB), .NUM_REGS(NR), .REG_AW(AW), .READ_LAT(RL), .ID_VALUE(IDV)) dut (
        .clk_125(clk_125), .rstn(rstn), .slv_bar_i(slv_bar_i), .slv_ce_i(slv_ce_i),
        .slv_we_i(slv_we_i), .slv_adr_i(slv_adr_i), .slv_dat_i(slv_dat_i), .slv_sel_i(slv_sel_i),
        .slv_dat_o(slv_dat_o), .slv_rvld_o(slv_rvld_o), .mem_ce_o(mem_ce_o), .mem_dat_i(mem_dat_i),
        .ctrl_o(ctrl_o), .stat_i(stat_i), .err_cnt_o(err_cnt_o)
    );

    always #4 clk_125 = ~clk_125;

    typedef struct { int due; logic [15:0] dat; } exp_t;
    typedef struct {
        logic [6:0] bar; logic we; logic [18:0] wa; logic [15:0] dat; logic [1:0] sel; logic [15:0] exp;
    } vec_t;

    exp_t        exp_q[$];
    logic [15:0] got_q[$];
    int          cyc = 0, n_vec = 0, n_err = 0;
    logic [31:0] mcnt;
    logic [15:0] mctrl [NR];
    logic [15:0] mshadow, msticky, exp_hold;
    logic [7:0]  merr;
    logic        mon_ev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lowest(input logic [NB-1:0] h);
        for (int b = 0; b < NB; b++) if (h[b]) return b;
        return -1;
    endfunction

    function automatic int popc(input logic [NB-1:0] h);
        int c = 0;
        for (int b = 0; b < NB; b++) c += int'(h[b]);
        return c;
    endfunction

    function automatic logic [15:0] memval(input int b, input logic [19:1] a);
        if (b == 1 && a[AW:1] == '0) return 16'hBEEF;
        return {4'(b), a[12:1]};
    endfunction

    function automatic logic [15:0] ref_read(input int tgt, input int o, input logic [19:1] a);
        if (tgt < 0) return 16'h0;
        if (tgt > 0) return memval(tgt, a);
        if (o < NR)      return mctrl[o];
        if (o == NR)     return IDV;
        if (o == NR + 1) return mcnt[15:0];
        if (o == NR + 2) return mshadow;
        if (o == NR + 3) return msticky;
        return 16'h0;
    endfunction

    function automatic logic [NB-1:0] exp_ce();
        logic [NB-1:0] m = '0;
        int t = lowest(slv_bar_i[NB-1:0]);
        if (slv_ce_i && t >= 1) m[t] = 1'b1;
        return m;
    endfunction

    // Memory targets: one-cycle Q when enabled, noise otherwise; slice 0 is always noise.
    always @(posedge clk_125) begin
        mem_dat_i[0] <= 16'($urandom);
        for (int b = 1; b < NB; b++)
            mem_dat_i[b] <= mem_ce_o[b] ? memval(b, slv_adr_i) : 16'($urandom);
    end

    always @(posedge clk_125) cyc <= cyc + 1;

    // Reference model: what each access does to the register map and what a read returns.
    always @(posedge clk_125 or negedge rstn) begin
        if (!rstn) begin
            mcnt <= '0; mshadow <= '0; msticky <= '0; merr <= '0;
            for (int k = 0; k < NR; k++) mctrl[k] <= '0;
            exp_q.delete();
        end else begin
            mcnt    <= mcnt + 1;
            msticky <= (msticky & ~((slv_ce_i && slv_we_i && lowest(slv_bar_i[NB-1:0]) == 0
                                     && int'(slv_adr_i[AW:1]) == NR + 3)
                                    ? ({{8{slv_sel_i[1]}}, {8{slv_sel_i[0]}}} & slv_dat_i) : 16'h0))
                       | stat_i;
            if (slv_ce_i) begin
                if (popc(slv_bar_i[NB-1:0]) != 1 && merr != 8'hFF) merr <= merr + 1;
                if (!slv_we_i) begin
                    exp_q.push_back('{due: cyc + RL,
                                      dat: ref_read(lowest(slv_bar_i[NB-1:0]), int'(slv_adr_i[AW:1]), slv_adr_i)});
                    if (lowest(slv_bar_i[NB-1:0]) == 0 && int'(slv_adr_i[AW:1]) == NR + 1)
                        mshadow <= mcnt[31:16];
                end else if (lowest(slv_bar_i[NB-1:0]) == 0 && int'(slv_adr_i[AW:1]) < NR) begin
                    if (slv_sel_i[0]) mctrl[int'(slv_adr_i[AW:1])][7:0]  <= slv_dat_i[7:0];
                    if (slv_sel_i[1]) mctrl[int'(slv_adr_i[AW:1])][15:8] <= slv_dat_i[15:8];
                end
            end
        end
    end

    always @(negedge clk_125) begin
        if (!rstn) exp_hold = 16'h0;
        mon_ev = exp_q.size() > 0 && exp_q[0].due == cyc;
        if (mon_ev) begin
            exp_hold = exp_q[0].dat;
            void'(exp_q.pop_front());
        end
        chk("rvld", 32'(slv_rvld_o), 32'(mon_ev));
        chk("rdata", 32'(slv_dat_o), 32'(exp_hold));
        if (slv_rvld_o) got_q.push_back(slv_dat_o);
        chk("err_cnt", 32'(err_cnt_o), 32'(merr));
        chk("mem_ce", 32'(mem_ce_o), 32'(exp_ce()));
        for (int k = 0; k < NR; k++) chk("ctrl_o", 32'(ctrl_o[k]), 32'(mctrl[k]));
    end

    task automatic access(input logic [6:0] bar, input logic we, input logic [18:0] wa,
                          input logic [15:0] dat, input logic [1:0] sel);
        @(posedge clk_125); #1;
        slv_bar_i = bar; slv_ce_i = 1'b1; slv_we_i = we;
        slv_adr_i = wa;  slv_dat_i = dat; slv_sel_i = sel;
    endtask

    task automatic idle();
        @(posedge clk_125); #1;
        slv_ce_i = 1'b0; slv_bar_i = 7'($urandom); slv_adr_i = 19'($urandom);
    endtask

    task automatic wait_ret(input string name, input int n);
        repeat (RL + 1) @(posedge clk_125);
        #1;
        chk(name, got_q.size(), n);
    endtask

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{7'b0000001, 1'b1, 19'd0,     16'hA55A, 2'b11, 16'h0};
        tbl[1]  = '{7'b0000001, 1'b0, 19'd0,     16'h0,    2'b11, 16'hA55A};
        tbl[2]  = '{7'b0000001, 1'b1, 19'd1,     16'hFFFF, 2'b11, 16'h0};
        tbl[3]  = '{7'b0000001, 1'b1, 19'd1,     16'h1234, 2'b01, 16'h0};
        tbl[4]  = '{7'b0000001, 1'b0, 19'd1,     16'h0,    2'b11, 16'hFF34};
        tbl[5]  = '{7'b0000001, 1'b0, 19'd8,     16'h0,    2'b11, 16'h8010};
        tbl[6]  = '{7'b0000001, 1'b1, 19'd8,     16'h0000, 2'b11, 16'h0};
        tbl[7]  = '{7'b1110001, 1'b0, 19'h40008, 16'h0,    2'b11, 16'h8010};
        tbl[8]  = '{7'b0000001, 1'b0, 19'd12,    16'h0,    2'b11, 16'h0000};
        tbl[9]  = '{7'b0000001, 1'b1, 19'd2,     16'hABCD, 2'b10, 16'h0};
        tbl[10] = '{7'b0000001, 1'b0, 19'h12,    16'h0,    2'b11, 16'hAB00};
        tbl[11] = '{7'b0000010, 1'b0, 19'd0,     16'h0,    2'b11, 16'hBEEF};
        tbl[12] = '{7'b0000110, 1'b0, 19'd0,     16'h0,    2'b11, 16'hBEEF};
        tbl[13] = '{7'b0000000, 1'b0, 19'd5,     16'h0,    2'b11, 16'h0000};

        repeat (3) @(negedge clk_125);
        chk("rst_dat", 32'(slv_dat_o), 32'h0);
        chk("rst_rvld", 32'(slv_rvld_o), 32'h0);
        chk("rst_err", 32'(err_cnt_o), 32'h0);
        chk("rst_ctrl", 32'(ctrl_o[0]), 32'h0);
        @(posedge clk_125); #1 rstn = 1'b1;

        for (int i = 0; i < 14; i++) begin
            got_q.delete();
            access(tbl[i].bar, tbl[i].we, tbl[i].wa, tbl[i].dat, tbl[i].sel);
            idle();
            if (!tbl[i].we) begin
                wait_ret("tbl_count", 1);
                if (got_q.size() > 0) chk("tbl_data", 32'(got_q[0]), 32'(tbl[i].exp));
            end
        end
        chk("tbl_err_cnt", 32'(err_cnt_o), 32'd2);
        chk("tbl_ctrl0", 32'(ctrl_o[0]), 32'hA55A);
        chk("tbl_ctrl1", 32'(ctrl_o[1]), 32'hFF34);

        // Sticky status: set, set-beats-clear, then clear alone.
        @(posedge clk_125); #1 stat_i = 16'h0008;
        @(posedge clk_125); #1 stat_i = 16'h0000;
        got_q.delete();
        access(7'b1, 1'b0, 19'(NR + 3), 16'h0, 2'b11);
        access(7'b1, 1'b1, 19'(NR + 3), 16'h0008, 2'b11);
        stat_i = 16'h0008;
        access(7'b1, 1'b0, 19'(NR + 3), 16'h0, 2'b11);
        stat_i = 16'h0000;
        access(7'b1, 1'b1, 19'(NR + 3), 16'h0008, 2'b01);
        access(7'b1, 1'b0, 19'(NR + 3), 16'h0, 2'b11);
        idle();
        wait_ret("stk_count", 3);
        if (got_q.size() == 3) begin
            chk("stk_set", 32'(got_q[0]), 32'h0008);
            chk("stk_set_wins", 32'(got_q[1]), 32'h0008);
            chk("stk_cleared", 32'(got_q[2]), 32'h0000);
        end

        for (int i = 0; i < 1500; i++) begin
            int r;
            @(posedge clk_125); #1;
            r = $urandom_range(0, 9);
            slv_ce_i  = $urandom_range(0, 9) < 8;
            slv_we_i  = $urandom_range(0, 9) < 4;
            slv_bar_i = (r < 6) ? 7'(1 << $urandom_range(0, NB - 1)) :
                        (r < 8) ? 7'($urandom) : (r == 8) ? (7'($urandom) & 7'b1111000) : 7'b0;
            slv_adr_i = 19'($urandom);
            slv_dat_i = 16'($urandom);
            slv_sel_i = 2'($urandom);
            stat_i    = ($urandom_range(0, 15) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0;
        end
        idle();
        stat_i = 16'h0;
        repeat (RL + 2) @(posedge clk_125);

        // Reset while a read is in flight: it must never come back.
        got_q.delete();
        access(7'b1, 1'b0, 19'd0, 16'h0, 2'b11);
        @(posedge clk_125); #1;
        slv_ce_i = 1'b0; rstn = 1'b0;
        repeat (2) @(posedge clk_125);
        #1 rstn = 1'b1;
        wait_ret("rst_inflight", 0);
        chk("rst2_dat", 32'(slv_dat_o), 32'h0);
        chk("rst2_err", 32'(err_cnt_o), 32'h0);

        // Counter snapshot across the 16-bit carry.
        while (mcnt < 32'hFFFE) begin
            @(posedge clk_125); #1;
        end
        got_q.delete();
        access(7'b1, 1'b0, 19'(NR + 1), 16'h0, 2'b11);
        access(7'b1, 1'b0, 19'(NR + 2), 16'h0, 2'b11);
        access(7'b1, 1'b0, 19'(NR + 1), 16'h0, 2'b11);
        access(7'b1, 1'b0, 19'(NR + 2), 16'h0, 2'b11);
        idle();
        wait_ret("cnt_count", 4);
        if (got_q.size() == 4) begin
            chk("cntl_ffff", 32'(got_q[0]), 32'hFFFF);
            chk("cnth_shadow0", 32'(got_q[1]), 32'h0000);
            chk("cntl_wrapped", 32'(got_q[2]), 32'h0001);
            chk("cnth_shadow1", 32'(got_q[3]), 32'h0001);
        end

        repeat (2) @(posedge clk_125);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
